// File: rtl/c17_pkg.sv
// Shared constants for the triple-redundant ISCAS C17 pipeline: mode codes,
// fault-injection select encoding, and per-channel bit positions.
// No logic; imported by c17_core and c17_tmr_pipe.
package c17_pkg;

  // Redundancy mode; code 3 is reserved and behaves like single mode.
  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_TMR    = 2'd1,
    MODE_DMR    = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  // fi_sel value that disables fault injection.
  localparam logic [1:0] FI_NONE = 2'd3;

  localparam int NREP  = 3;  // replicas per channel
  localparam int IN_W  = 5;  // input bits per channel
  localparam int OUT_W = 2;  // output bits per channel

  // Input bit positions within a channel's 5-bit slice.
  localparam int G1_IDX = 0;
  localparam int G2_IDX = 1;
  localparam int G3_IDX = 2;
  localparam int G6_IDX = 3;
  localparam int G7_IDX = 4;

  // Output bit positions within a channel's 2-bit slice.
  localparam int G22_IDX = 0;
  localparam int G23_IDX = 1;

endpackage

// File: rtl/c17_core.sv
// Purpose : one ISCAS C17 NAND network (5 inputs -> G22, G23).
// Latency : purely combinational.
// Backpressure: none; ports g_in[4:0] = {G7,G6,G3,G2,G1}, g_out[1:0] = {G23,G22}.
module c17_core
  import c17_pkg::*;
(
  input  logic [IN_W-1:0]  g_in,
  output logic [OUT_W-1:0] g_out
);

  logic g1, g2, g3, g6, g7;

  assign g1 = g_in[G1_IDX];
  assign g2 = g_in[G2_IDX];
  assign g3 = g_in[G3_IDX];
  assign g6 = g_in[G6_IDX];
  assign g7 = g_in[G7_IDX];

  assign g_out[G22_IDX] = ~(~(g1 & g3) & ~(g2 & ~(g3 & g6)));
  assign g_out[G23_IDX] = ~((g3 & g6) | (~g2 & ~g7));

endmodule

// File: rtl/c17_tmr_pipe.sv
// Purpose : NCH C17 channels, each computed by three replicas, voted/compared per mode, with error counting.
// Latency : 2 cycles (S1 input register, S2 result register) from input transfer to out_valid.
// Backpressure: valid/ready; S2 holds while out_valid & ~out_ready, S1 advances only when S2 can take it.
// Ports   : clk/rst (async active-high); in_valid/in_ready/in_data[5*NCH]; mode, fi_sel, fi_mask[2*NCH]
//           sampled with each input; out_valid/out_ready/out_data[2*NCH]/out_err[NCH]; cnt_clr, err_cnt[CNTW].
module c17_tmr_pipe
  import c17_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int CNTW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W*NCH-1:0]   in_data,
  input  logic [1:0]            mode,
  input  logic [1:0]            fi_sel,
  input  logic [OUT_W*NCH-1:0]  fi_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W*NCH-1:0]  out_data,
  output logic [NCH-1:0]        out_err,
  input  logic                  cnt_clr,
  output logic [CNTW-1:0]       err_cnt
);

  localparam int DW = OUT_W * NCH;

  // ---------------- S1: captured transaction ----------------
  logic                  s1_vld_q, s1_vld_d;
  logic [IN_W*NCH-1:0]   s1_dat_q, s1_dat_d;
  mode_e                 s1_mode_q, s1_mode_d;
  logic [1:0]            s1_fi_sel_q, s1_fi_sel_d;
  logic [DW-1:0]         s1_fi_mask_q, s1_fi_mask_d;

  // ---------------- S2: voted result ----------------
  logic                  s2_vld_q, s2_vld_d;
  logic [DW-1:0]         s2_dat_q, s2_dat_d;
  logic [NCH-1:0]        s2_err_q, s2_err_d;

  logic [CNTW-1:0]       err_cnt_q, err_cnt_d;

  // ---------------- flow control ----------------
  logic s2_adv;
  logic in_xfer;
  logic out_xfer;

  // S2 can accept whenever it is empty or its content leaves this cycle;
  // S1 always empties into S2 at that moment.
  assign s2_adv   = ~s2_vld_q | out_ready;
  assign in_ready = ~s1_vld_q | s2_adv;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = s2_vld_q & out_ready;

  // ---------------- replicas ----------------
  logic [NREP-1:0][DW-1:0] rep_raw;
  logic [NREP-1:0][DW-1:0] rep;

  for (genvar r = 0; r < NREP; r++) begin : g_rep
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      c17_core u_core (
        .g_in  (s1_dat_q[IN_W*c +: IN_W]),
        .g_out (rep_raw[r][OUT_W*c +: OUT_W])
      );
    end
    // Mask lands on the selected replica only; FI_NONE matches no replica.
    assign rep[r] = rep_raw[r] ^ ((s1_fi_sel_q == 2'(r)) ? s1_fi_mask_q : '0);
  end

  // ---------------- vote / compare ----------------
  logic [DW-1:0]  maj;
  logic [DW-1:0]  diff01;
  logic [DW-1:0]  diff02;
  logic [DW-1:0]  vote_dat;
  logic [NCH-1:0] vote_err;

  assign maj    = (rep[0] & rep[1]) | (rep[0] & rep[2]) | (rep[1] & rep[2]);
  assign diff01 = rep[0] ^ rep[1];
  assign diff02 = rep[0] ^ rep[2];

  always_comb begin
    vote_dat = rep[0];
    vote_err = '0;
    case (s1_mode_q)
      MODE_TMR: begin
        vote_dat = maj;
        // With three replicas, "some replica disagrees" reduces to
        // replica 0 differing from either of the others.
        for (int c = 0; c < NCH; c++) begin
          vote_err[c] = (|diff01[OUT_W*c +: OUT_W]) | (|diff02[OUT_W*c +: OUT_W]);
        end
      end
      MODE_DMR: begin
        for (int c = 0; c < NCH; c++) begin
          vote_err[c] = |diff01[OUT_W*c +: OUT_W];
        end
      end
      default: begin
        vote_dat = rep[0];
        vote_err = '0;
      end
    endcase
  end

  // ---------------- next state ----------------
  always_comb begin
    s1_vld_d     = s1_vld_q;
    s1_dat_d     = s1_dat_q;
    s1_mode_d    = s1_mode_q;
    s1_fi_sel_d  = s1_fi_sel_q;
    s1_fi_mask_d = s1_fi_mask_q;
    s2_vld_d     = s2_vld_q;
    s2_dat_d     = s2_dat_q;
    s2_err_d     = s2_err_q;
    err_cnt_d    = err_cnt_q;

    if (in_ready) begin
      s1_vld_d = in_valid;
    end
    if (in_xfer) begin
      s1_dat_d     = in_data;
      s1_mode_d    = mode_e'(mode);
      s1_fi_sel_d  = fi_sel;
      s1_fi_mask_d = fi_mask;
    end

    // Data/err only change when a real result loads, so a held or
    // emptied S2 keeps its last values.
    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_dat_d = vote_dat;
        s2_err_d = vote_err;
      end
    end

    if (cnt_clr) begin
      err_cnt_d = '0;
    end else if (out_xfer && (|s2_err_q) && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + CNTW'(1);
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q     <= 1'b0;
      s1_dat_q     <= '0;
      s1_mode_q    <= MODE_SINGLE;
      s1_fi_sel_q  <= FI_NONE;
      s1_fi_mask_q <= '0;
      s2_vld_q     <= 1'b0;
      s2_dat_q     <= '0;
      s2_err_q     <= '0;
      err_cnt_q    <= '0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_dat_q     <= s1_dat_d;
      s1_mode_q    <= s1_mode_d;
      s1_fi_sel_q  <= s1_fi_sel_d;
      s1_fi_mask_q <= s1_fi_mask_d;
      s2_vld_q     <= s2_vld_d;
      s2_dat_q     <= s2_dat_d;
      s2_err_q     <= s2_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign out_valid = s2_vld_q;
  assign out_data  = s2_dat_q;
  assign out_err   = s2_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_c17_tmr_pipe.sv
// Purpose : directed self-checking bench for c17_tmr_pipe (NCH=2, CNTW=4).
// Latency : drives just after the rising edge, samples on the falling edge.
// Backpressure: exercised via out_ready stalls in the streaming section.
module tb_c17_tmr_pipe;

  localparam int NCH  = 2;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [5*NCH-1:0] in_data;
  logic [1:0]      mode;
  logic [1:0]      fi_sel;
  logic [2*NCH-1:0] fi_mask;
  logic            out_valid;
  logic            out_ready;
  logic [2*NCH-1:0] out_data;
  logic [NCH-1:0]  out_err;
  logic            cnt_clr;
  logic [CNTW-1:0] err_cnt;

  c17_tmr_pipe #(.NCH(NCH), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .fi_sel    (fi_sel),
    .fi_mask   (fi_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .cnt_clr   (cnt_clr),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Hand-evaluated C17 vectors: input {G7,G6,G3,G2,G1} -> {G23,G22}.
  logic [4:0] tab_in [8];
  logic [1:0] tab_ex [8];

  function automatic logic [9:0] svec(input int i);
    return {tab_in[7-i], tab_in[i]};
  endfunction

  function automatic logic [3:0] sexp(input int i);
    return {tab_ex[7-i], tab_ex[i]};
  endfunction

  // One isolated transaction with out_ready high; checks latency, result,
  // in-flight immunity to control changes, and the counter afterwards.
  task automatic run_txn(input string tag, input logic [9:0] din, input logic [1:0] md,
                         input logic [1:0] sel, input logic [3:0] msk,
                         input logic [3:0] exp_d, input logic [1:0] exp_e, input int exp_cnt);
    in_valid = 1'b1; in_data = din; mode = md; fi_sel = sel; fi_mask = msk; out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_inrdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = ~din; mode = md ^ 2'b01; fi_sel = sel ^ 2'b01; fi_mask = ~msk;
    @(negedge clk);
    chk({tag, "_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_dat"}, 32'(out_data), 32'(exp_d));
    chk({tag, "_err"}, 32'(out_err), 32'(exp_e));
    @(negedge clk);
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
    chk({tag, "_cnt"}, 32'(err_cnt), 32'(exp_cnt));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, rcv, stall, seen;

    tab_in = '{5'b01101, 5'b00010, 5'b00000, 5'b11111, 5'b10000, 5'b00001, 5'b10010, 5'b10100};
    tab_ex = '{2'b01,    2'b11,    2'b00,    2'b01,    2'b10,    2'b00,    2'b11,    2'b10};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 2'd0; fi_sel = 2'd3; fi_mask = '0;
    out_ready = 1'b1; cnt_clr = 1'b0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_dat", 32'(out_data), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_inrdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // ---- directed single transactions (ch1 in upper bits) ----
    run_txn("single",  {5'b00000, 5'b01101}, 2'd0, 2'd3, 4'b0000, 4'b0001, 2'b00, 0);
    run_txn("tmr_fi1", {5'b11111, 5'b00010}, 2'd1, 2'd1, 4'b0011, 4'b0111, 2'b01, 1);
    run_txn("tmr_nofi",{5'b11111, 5'b00010}, 2'd1, 2'd3, 4'b1111, 4'b0111, 2'b00, 1);
    run_txn("tmr_fi2", {5'b10000, 5'b00010}, 2'd1, 2'd2, 4'b1100, 4'b1011, 2'b10, 2);
    run_txn("dmr_fi2", {5'b10000, 5'b00010}, 2'd2, 2'd2, 4'b1111, 4'b1011, 2'b00, 2);
    run_txn("dmr_fi0", {5'b10000, 5'b00010}, 2'd2, 2'd0, 4'b0011, 4'b1000, 2'b01, 3);
    run_txn("dmr_fi1", {5'b10000, 5'b00010}, 2'd2, 2'd1, 4'b1100, 4'b1011, 2'b10, 4);
    run_txn("mode3",   {5'b10000, 5'b00010}, 2'd3, 2'd0, 4'b0011, 4'b1000, 2'b00, 4);
    run_txn("single_fi",{5'b10000, 5'b00010}, 2'd0, 2'd1, 4'b1111, 4'b1011, 2'b00, 4);
    run_txn("tmr_fi0", {5'b10010, 5'b00001}, 2'd1, 2'd0, 4'b0001, 4'b1100, 2'b01, 5);

    // ---- back-to-back stream with a 3-cycle output stall ----
    sent = 0; rcv = 0; stall = 0;
    mode = 2'd0; fi_sel = 2'd3; fi_mask = '0;
    in_valid = 1'b1; in_data = svec(0); out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (rcv < 8) chk($sformatf("stream_dat%0d", rcv), 32'(out_data), 32'(sexp(rcv)));
        chk($sformatf("stream_err%0d", rcv), 32'(out_err), 32'd0);
        if (out_ready) rcv++;
      end
      if (in_valid && !in_ready) stall++;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      in_valid  = (sent < 8);
      in_data   = (sent < 8) ? svec(sent) : '0;
      out_ready = !((cyc + 1) >= 3 && (cyc + 1) <= 5);
    end
    chk("stream_sent", 32'(sent), 32'd8);
    chk("stream_rcv", 32'(rcv), 32'd8);
    chk("stream_inrdy_low", 32'(stall), 32'd3);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    // ---- counter clear then saturation ----
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_only", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = {5'b10010, 5'b00001}; mode = 2'd1; fi_sel = 2'd0; fi_mask = 4'b0001;
    repeat (20) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sat_cnt", 32'(err_cnt), 32'd15);
    @(posedge clk); #1;

    // ---- reset with two transactions in flight ----
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = {5'b00000, 5'b01101}; mode = 2'd0; fi_sel = 2'd3; fi_mask = '0;
    @(posedge clk); #1;
    in_data = {5'b11111, 5'b00010};
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl_full_vld", 32'(out_valid), 32'd1);
    chk("fl_full_inrdy", 32'(in_ready), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("fl_rst_vld", 32'(out_valid), 32'd0);
    chk("fl_rst_dat", 32'(out_data), 32'd0);
    chk("fl_rst_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("fl_no_stale", 32'(seen), 32'd0);
    chk("fl_inrdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // ---- clear coinciding with an erroneous output transfer ----
    run_txn("pre_clr", {5'b10010, 5'b00001}, 2'd1, 2'd0, 4'b0001, 4'b1100, 2'b01, 1);
    in_valid = 1'b1; in_data = {5'b10010, 5'b00001}; mode = 2'd1; fi_sel = 2'd0; fi_mask = 4'b0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    cnt_clr = 1'b1;
    @(negedge clk);
    chk("clrx_vld", 32'(out_valid), 32'd1);
    chk("clrx_err", 32'(out_err), 32'd1);
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clrx_cnt", 32'(err_cnt), 32'd0);
    chk("clrx_drain", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/c17_tmr_pipe.md
C17_TMR_PIPE -- requirements
Module: c17_tmr_pipe

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent C17 channels (1..32).
REQ-002 SHALL have parameter CNTW, default 16, error-counter width (4..32).
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  in  1  input transfer request.
REQ-006 SHALL have port in_ready  out  1  input accept; transfer when in_valid&in_ready.
REQ-007 SHALL have port in_data  in  5*NCH  channel c: bit 5c+0=G1, +1=G2, +2=G3, +3=G6, +4=G7.
REQ-008 SHALL have port mode  in  2  0=single, 1=TMR vote, 2=DMR compare, 3=treated as 0.
REQ-009 SHALL have port fi_sel  in  2  fault-injection replica 0..2; 3=no injection.
REQ-010 SHALL have port fi_mask  in  2*NCH  XOR mask applied to the selected replica's outputs.
REQ-011 SHALL have port out_valid  out  1  result available.
REQ-012 SHALL have port out_ready  in  1  downstream accept.
REQ-013 SHALL have port out_data  out  2*NCH  channel c: bit 2c+0=G22, 2c+1=G23.
REQ-014 SHALL have port out_err  out  NCH  per-channel replica disagreement.
REQ-015 SHALL have port cnt_clr  in  1  synchronous error-counter clear.
REQ-016 SHALL have port err_cnt  out  CNTW  saturating count of erroneous output transfers.

Function
REQ-017 Each replica SHALL compute G22 = ~(~(G1&G3) & ~(G2&~(G3&G6))) and G23 = ~((G3&G6) | (~G2&~G7)).
REQ-018 SHALL have two register stages: S1 captures in_data, mode, fi_sel, fi_mask on the input transfer; S2 holds the voted result. Latency is 2 cycles from input transfer to out_valid with out_ready held high.
REQ-019 mode, fi_sel and fi_mask SHALL be sampled per transaction at S1; later changes SHALL NOT affect in-flight data.
REQ-020 Three replicas (0,1,2) per channel; fi_mask SHALL be XORed onto replica fi_sel's outputs only.
REQ-021 mode 0/3: out_data = replica 0; out_err = 0.
REQ-022 mode 1: out_data = bitwise majority of replicas 0..2; out_err[c] = 1 if any replica differs from the others on either bit of channel c.
REQ-023 mode 2: out_data = replica 0; out_err[c] = 1 if replicas 0 and 1 differ on channel c; replica 2 is ignored.
REQ-024 Backpressure: S2 SHALL hold when out_valid&~out_ready. S1 SHALL advance when S2 is empty or drains. in_ready = ~S1_valid | S1 advancing. No transfer SHALL be lost or duplicated; full throughput is 1 per cycle.
REQ-025 out_data and out_err SHALL be stable while out_valid&~out_ready.
REQ-026 err_cnt SHALL increment by 1 on each output transfer with |out_err, saturating at 2^CNTW-1.
REQ-027 cnt_clr SHALL zero err_cnt next cycle and take priority over a simultaneous increment.

Reset
REQ-028 rst SHALL asynchronously force S1/S2 valid=0, out_valid=0, out_data=0, out_err=0, err_cnt=0; in_ready=1 after release.
REQ-029 Reset mid-operation SHALL discard all in-flight transactions, with no output produced for them.

Structure
REQ-030 Package c17_pkg SHALL hold MODE_SINGLE/MODE_TMR/MODE_DMR constants, FI_NONE=3, and the per-channel bit-index constants.
REQ-031 Combinational sub-module c17_core (5 in, 2 out) SHALL be instantiated 3*NCH times; majority and compare logic SHALL stay in the top level.

Verification
REQ-032 NCH=1, mode 0, in_data=5'b01101 -> out_data=2'b01 two cycles later, out_err=0.
REQ-033 NCH=1, mode 1, in_data=5'b00010, fi_sel=1, fi_mask=2'b11 -> out_data=2'b11, out_err=1, err_cnt 0->1.
REQ-034 mode 2, fi_sel=2, fi_mask=2'b11 -> out_err=0, out_data unaffected; with fi_sel=0 instead -> out_data=2'b11 XOR mask, out_err=1.
REQ-035 Back-to-back 8 transfers, out_ready low for 3 cycles mid-stream -> all 8 results in order, no loss, in_ready deasserts while both stages are full.
REQ-036 CNTW=4, 20 erroneous transfers -> err_cnt saturates at 15; cnt_clr together with an error transfer -> err_cnt=0.
REQ-037 rst asserted with 2 transactions in flight -> out_valid=0 immediately; no stale output after release.
